cdr_delay_line_controller: RTL and testbench

Digitally controlled variable delay line for the PRN-based CDR loop. It delays the 1-bit recovered data stream `din` by a programmable number of clock cycles. The phase-detector/loop-filter logic steps that delay up or down one tap at a time with `shift_right` and `shift_left`. `dout` feeds the PRN correlator and phase detector downstream.

---
 rtl/dlc_pkg.sv | 27 ++
 rtl/dlc_tap_counter.sv | 49 ++++
 rtl/cdr_delay_line_controller.sv | 68 ++++++
 tb/tb_cdr_delay_line_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dlc_pkg.sv
// Shared definitions for the CDR delay line controller.
//   DLC_DEPTH_DEF / DLC_INIT_TAP_DEF : default tap count and reset tap
//   dlc_cmd_e                        : decoded tap command
//   dlc_decode()                     : {shift_right, shift_left} -> dlc_cmd_e
package dlc_pkg;

  localparam int unsigned DLC_DEPTH_DEF    = 32;
  localparam int unsigned DLC_INIT_TAP_DEF = 0;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } dlc_cmd_e;

  // Conflicting commands (both high) are treated as no-op.
  function automatic dlc_cmd_e dlc_decode(input logic shift_right, input logic shift_left);
    dlc_cmd_e cmd;
    unique case ({shift_right, shift_left})
      2'b10:   cmd = INC;
      2'b01:   cmd = DEC;
      default: cmd = HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/dlc_tap_counter.sv
// Saturating up/down tap counter for the delay line.
// Ports:
//   clk, rst (async, active-low)
//   shift_right / shift_left : level commands, one step per cycle
//   tap                      : current tap index
//   at_min / at_max          : tap at 0 / at DEPTH-1
module dlc_tap_counter
  import dlc_pkg::*;
#(
  parameter int unsigned DEPTH    = DLC_DEPTH_DEF,
  parameter int unsigned INIT_TAP = DLC_INIT_TAP_DEF,
  localparam int unsigned TW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_right,
  input  logic          shift_left,
  output logic [TW-1:0] tap,
  output logic          at_min,
  output logic          at_max
);

  logic [TW-1:0] tap_d, tap_q;
  dlc_cmd_e      cmd;

  assign cmd    = dlc_decode(shift_right, shift_left);
  assign at_min = (tap_q == '0);
  assign at_max = (tap_q == TW'(DEPTH - 1));
  assign tap    = tap_q;

  // Saturate silently at both ends; never wrap.
  always_comb begin
    tap_d = tap_q;
    unique case (cmd)
      INC:     if (!at_max) tap_d = tap_q + TW'(1);
      DEC:     if (!at_min) tap_d = tap_q - TW'(1);
      default: tap_d = tap_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_q <= TW'(INIT_TAP);
    end else begin
      tap_q <= tap_d;
    end
  end

endmodule

// File: rtl/cdr_delay_line_controller.sv
// Programmable delay line for the PRN-based CDR loop: delays din by tap+1 cycles,
// with the tap stepped one position per cycle by shift_right / shift_left.
// Ports:
//   clk, rst (async, active-low)
//   din                      : serial data in
//   shift_right / shift_left : increase / decrease delay (level commands)
//   dout                     : din delayed by tap+1 cycles
//   tap, at_min, at_max      : status, present only when DLC_STATUS_EN is defined
// Configuration macro: DLC_STATUS_EN
module cdr_delay_line_controller
  import dlc_pkg::*;
#(
  parameter int unsigned DEPTH    = DLC_DEPTH_DEF,
  parameter int unsigned INIT_TAP = DLC_INIT_TAP_DEF,
  localparam int unsigned TW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          shift_right,
  input  logic          shift_left,
`ifdef DLC_STATUS_EN
  output logic [TW-1:0] tap,
  output logic          at_min,
  output logic          at_max,
`endif
  output logic          dout
);

  logic [DEPTH-1:0] sr_q;
  logic [TW-1:0]    tap_w;
  logic             at_min_w, at_max_w;

  dlc_tap_counter #(
    .DEPTH    (DEPTH),
    .INIT_TAP (INIT_TAP)
  ) u_tap_counter (
    .clk         (clk),
    .rst         (rst),
    .shift_right (shift_right),
    .shift_left  (shift_left),
    .tap         (tap_w),
    .at_min      (at_min_w),
    .at_max      (at_max_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DEPTH-2:0], din};
    end
  end

  // Mux of registered state only: the new tap selects from the freshly shifted
  // register, so a step repeats or skips exactly one bit.
  assign dout = sr_q[tap_w];

`ifdef DLC_STATUS_EN
  assign tap    = tap_w;
  assign at_min = at_min_w;
  assign at_max = at_max_w;
`else
  logic unused_status;
  assign unused_status = at_min_w ^ at_max_w;
`endif

endmodule

// File: tb/tb_cdr_delay_line_controller.sv
// Directed bench for cdr_delay_line_controller. A reference model of the delay
// history and tap pushes the expected dout (and tap) when stimulus is driven;
// entries are popped and compared one time unit after the following rising edge.
module tb_cdr_delay_line_controller;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned TW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b1;
  logic shift_r = 1'b0;
  logic shift_l = 1'b0;
  logic dout;
`ifdef DLC_STATUS_EN
  logic [TW-1:0] tap;
  logic          at_min, at_max;
`endif

  cdr_delay_line_controller #(
    .DEPTH    (DEPTH),
    .INIT_TAP (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .shift_right (shift_r),
    .shift_left  (shift_l),
`ifdef DLC_STATUS_EN
    .tap         (tap),
    .at_min      (at_min),
    .at_max      (at_max),
`endif
    .dout        (dout)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic hist[DEPTH];
  int   m_tap;
  logic exp_q[$];
  int   exp_tap_q[$];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) hist[i] = 1'b0;
    m_tap = 0;
    exp_q.delete();
    exp_tap_q.delete();
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic d, input logic r, input logic l, input string tag);
    logic exp_b;
    int   exp_t;
    din     = d;
    shift_r = r;
    shift_l = l;
    if (r && !l && m_tap < DEPTH - 1) m_tap++;
    else if (!r && l && m_tap > 0) m_tap--;
    for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
    exp_q.push_back(hist[m_tap]);
    exp_tap_q.push_back(m_tap);
    @(posedge clk);
    #1;
    exp_b = exp_q.pop_front();
    exp_t = exp_tap_q.pop_front();
    check_bit({tag, "_dout"}, dout, exp_b);
`ifdef DLC_STATUS_EN
    check_int({tag, "_tap"}, int'(tap), exp_t);
    check_bit({tag, "_at_min"}, at_min, exp_t == 0);
    check_bit({tag, "_at_max"}, at_max, exp_t == DEPTH - 1);
`else
    if (exp_t < 0) $display("unexpected negative model tap");
`endif
    @(negedge clk);
  endtask

  function automatic logic rnd_bit();
    return $urandom_range(1, 0) != 0;
  endfunction

  logic [19:0] pat;

  initial begin
    // Reset held two cycles with din=1.
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("reset_dout", dout, 1'b0);
`ifdef DLC_STATUS_EN
    check_int("reset_tap", int'(tap), 0);
    check_bit("reset_at_min", at_min, 1'b1);
`endif
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, "post_reset");
    step(1'b1, 1'b0, 1'b0, "post_reset2");

    // Fixed 1-cycle delay on a known pattern.
    pat = 20'b0001_1000_0110_0101_0001;
    for (int i = 19; i >= 0; i--) step(pat[i], 1'b0, 1'b0, "fixed");

    // Increase delay to tap 14, then observe a 15-cycle delay.
    repeat (14) step(rnd_bit(), 1'b1, 1'b0, "inc");
    repeat (40) step(rnd_bit(), 1'b0, 1'b0, "delay15");

    // Conflicting commands hold the tap.
    repeat (20) step(rnd_bit(), 1'b1, 1'b1, "both");

    // Decrease into and through the lower bound.
    repeat (40) step(rnd_bit(), 1'b0, 1'b1, "dec_sat");
    repeat (8)  step(rnd_bit(), 1'b0, 1'b0, "min_hold");

    // Increase into and through the upper bound.
    repeat (40) step(rnd_bit(), 1'b1, 1'b0, "inc_sat");
    repeat (40) step(rnd_bit(), 1'b0, 1'b0, "max_hold");

    // Down to tap 5, then alternating single-cycle commands.
    repeat (26) step(rnd_bit(), 1'b0, 1'b1, "to5");
    repeat (10) step(rnd_bit(), 1'b0, 1'b0, "tap5");
    step(rnd_bit(), 1'b0, 1'b1, "alt_l1");
    step(rnd_bit(), 1'b0, 1'b0, "alt_n");
    step(rnd_bit(), 1'b0, 1'b1, "alt_l2");
    step(rnd_bit(), 1'b1, 1'b1, "alt_b");
    step(rnd_bit(), 1'b0, 1'b1, "alt_l3");
    repeat (10) step(rnd_bit(), 1'b0, 1'b0, "tap2");

    // Asynchronous reset mid-operation with ones in flight.
    repeat (8) step(1'b1, 1'b1, 1'b0, "ones");
    #3;
    rst = 1'b0;
    #1;
    check_bit("midreset_dout", dout, 1'b0);
`ifdef DLC_STATUS_EN
    check_int("midreset_tap", int'(tap), 0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, "after_mid1");
    repeat (6) step(rnd_bit(), 1'b0, 1'b0, "after_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
